// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard controller (slave).
// Carries decode/execute/writeback register info in, and stall/flush/PC/forwarding controls out.
interface pipeline_hazard_ctrl_if;
  localparam int unsigned REG_W = 3;
  localparam int unsigned FWD_W = 2;

  // Register usage reported by the pipeline stages
  logic [REG_W-1:0] d_rs1;
  logic [REG_W-1:0] d_rs2;
  logic             d_use_rs1;
  logic             d_use_rs2;
  logic [REG_W-1:0] e_rd;
  logic             e_reg_write;
  logic             e_mem_read;
  logic             e_multicycle;
  logic             e_branch_taken;
  logic [REG_W-1:0] w_rd;
  logic             w_reg_write;
  logic             halt_req;

  // Controls returned to the stage registers, PC and operand muxes
  logic             stall_F;
  logic             stall_D;
  logic             flush_F;
  logic             flush_D;
  logic             pc_write_en;
  logic             pc_sel_branch;
  logic             wb_suppress;
  logic             halt_ack;
  logic [FWD_W-1:0] fwd_a;
  logic [FWD_W-1:0] fwd_b;

  modport master (
    output d_rs1, d_rs2, d_use_rs1, d_use_rs2,
    output e_rd, e_reg_write, e_mem_read, e_multicycle, e_branch_taken,
    output w_rd, w_reg_write, halt_req,
    input  stall_F, stall_D, flush_F, flush_D, pc_write_en, pc_sel_branch,
    input  wb_suppress, halt_ack, fwd_a, fwd_b
  );

  modport slave (
    input  d_rs1, d_rs2, d_use_rs1, d_use_rs2,
    input  e_rd, e_reg_write, e_mem_read, e_multicycle, e_branch_taken,
    input  w_rd, w_reg_write, halt_req,
    output stall_F, stall_D, flush_F, flush_D, pc_write_en, pc_sel_branch,
    output wb_suppress, halt_ack, fwd_a, fwd_b
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: RAW stalls/forwarding, multi-cycle E sequencing, branch flush, debug halt/drain.
// Optional operand forwarding is enabled by defining HAZARD_FWD_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned MC_CYCLES = 4
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned FWD_W = 2;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_DRAIN = CNT_W'(1);

  localparam logic [FWD_W-1:0] FWD_RF = 2'b00;
  localparam logic [FWD_W-1:0] FWD_E  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_W_SEL = 2'b10;

  typedef enum logic [1:0] {RUN, MULTI, DRAIN, HALTED} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_ack_q;

  logic             stall_f, stall_d, flush_f, flush_d;
  logic             pc_we, pc_br, wb_sup;
  logic [FWD_W-1:0] fwd_a_c, fwd_b_c;

  // Per-operand source matches against E and W destinations
  logic m_e_a, m_e_b, m_w_a, m_w_b;
  logic m_e, m_w, load_use, raw_stall;

  assign m_e_a = hz.e_reg_write && hz.d_use_rs1 && (hz.e_rd == hz.d_rs1);
  assign m_e_b = hz.e_reg_write && hz.d_use_rs2 && (hz.e_rd == hz.d_rs2);
  assign m_w_a = hz.w_reg_write && hz.d_use_rs1 && (hz.w_rd == hz.d_rs1);
  assign m_w_b = hz.w_reg_write && hz.d_use_rs2 && (hz.w_rd == hz.d_rs2);
  assign m_e      = m_e_a || m_e_b;
  assign m_w      = m_w_a || m_w_b;
  assign load_use = m_e && hz.e_mem_read;

`ifdef HAZARD_FWD_EN
  // Only a load in E cannot be bypassed; E result wins over W result
  assign raw_stall = load_use;

  always_comb begin
    fwd_a_c = FWD_RF;
    fwd_b_c = FWD_RF;
    if (m_e_a && !hz.e_mem_read) fwd_a_c = FWD_E;
    else if (m_w_a)              fwd_a_c = FWD_W_SEL;
    if (m_e_b && !hz.e_mem_read) fwd_b_c = FWD_E;
    else if (m_w_b)              fwd_b_c = FWD_W_SEL;
  end
`else
  assign raw_stall = m_e || m_w;
  assign fwd_a_c   = FWD_RF;
  assign fwd_b_c   = FWD_RF;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      halt_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      halt_ack_q <= (state_d == HALTED);
    end
  end

  // Next state and zero-latency stage controls
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_f = 1'b0;
    flush_d = 1'b0;
    pc_we   = 1'b1;
    pc_br   = 1'b0;
    wb_sup  = 1'b0;

    case (state_q)
      RUN: begin
        if (!hz.e_branch_taken) begin
          if (hz.e_multicycle) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            wb_sup  = 1'b1;
            pc_we   = 1'b0;
            state_d = MULTI;
            cnt_d   = CNT_W'(1);
          end else if (raw_stall) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
            pc_we   = 1'b0;
          end else if (hz.halt_req) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
      end
      MULTI: begin
        if (cnt_q < CNT_LAST) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          wb_sup  = 1'b1;
          pc_we   = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        stall_f = 1'b1;
        flush_d = 1'b1;
        pc_we   = 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);
        if (!hz.halt_req) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_DRAIN) begin
          state_d = HALTED;
          cnt_d   = '0;
        end
      end
      HALTED: begin
        stall_f = 1'b1;
        flush_d = 1'b1;
        pc_we   = 1'b0;
        if (!hz.halt_req) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    // A taken branch redirects everywhere except inside a multi-cycle op
    if (hz.e_branch_taken && (state_q != MULTI)) begin
      flush_f = 1'b1;
      flush_d = 1'b1;
      pc_br   = 1'b1;
      pc_we   = 1'b1;
      stall_f = 1'b0;
      stall_d = 1'b0;
      wb_sup  = 1'b0;
    end

    if (reset) begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_f = 1'b0;
      flush_d = 1'b0;
      pc_we   = 1'b0;
      pc_br   = 1'b0;
      wb_sup  = 1'b0;
    end
  end

  assign hz.stall_F       = stall_f;
  assign hz.stall_D       = stall_d;
  assign hz.flush_F       = flush_f;
  assign hz.flush_D       = flush_d;
  assign hz.pc_write_en   = pc_we;
  assign hz.pc_sel_branch = pc_br;
  assign hz.wb_suppress   = wb_sup;
  assign hz.halt_ack      = halt_ack_q;
  assign hz.fwd_a         = reset ? FWD_RF : fwd_a_c;
  assign hz.fwd_b         = reset ? FWD_RF : fwd_b_c;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl; expectations follow HAZARD_FWD_EN when it is defined.
module tb_pipeline_hazard_ctrl;
  localparam int unsigned MC = 4;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Control vector order: stall_F stall_D flush_F flush_D pc_write_en pc_sel_branch wb_suppress halt_ack
  localparam logic [7:0] C_ZERO   = 8'b0000_0000;
  localparam logic [7:0] C_IDLE   = 8'b0000_1000;
  localparam logic [7:0] C_BUBBLE = 8'b1001_0000;
  localparam logic [7:0] C_MC     = 8'b1100_0010;
  localparam logic [7:0] C_BRANCH = 8'b0011_1100;
  localparam logic [7:0] C_HALT   = 8'b1001_0001;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_ctrl_if hz();

  pipeline_hazard_ctrl #(.MC_CYCLES(MC)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  logic [11:0] obs;
  assign obs = {hz.stall_F, hz.stall_D, hz.flush_F, hz.flush_D, hz.pc_write_en,
                hz.pc_sel_branch, hz.wb_suppress, hz.halt_ack, hz.fwd_a, hz.fwd_b};

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got ctrl=%b fwd_a=%b fwd_b=%b, expected ctrl=%b fwd_a=%b fwd_b=%b",
               tag, got[11:4], got[3:2], got[1:0], exp[11:4], exp[3:2], exp[1:0]);
    end
  endtask

  task automatic clear_inputs();
    hz.d_rs1 = '0; hz.d_rs2 = '0; hz.d_use_rs1 = 1'b0; hz.d_use_rs2 = 1'b0;
    hz.e_rd = '0; hz.e_reg_write = 1'b0; hz.e_mem_read = 1'b0;
    hz.e_multicycle = 1'b0; hz.e_branch_taken = 1'b0;
    hz.w_rd = '0; hz.w_reg_write = 1'b0; hz.halt_req = 1'b0;
  endtask

  // Sample mid-cycle, then advance to just after the next rising edge
  task automatic expect_cycle(input string tag, input logic [7:0] c,
                              input logic [1:0] fa, input logic [1:0] fb);
    @(negedge clk);
    check(tag, obs, {c, fa, fb});
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    check("reset_state", obs, {C_ZERO, 4'b0000});
    @(posedge clk); #1;
    reset = 1'b0;
    expect_cycle("idle_run", C_IDLE, 2'b00, 2'b00);

    // Load-use on rs1
    hz.e_reg_write = 1'b1; hz.e_mem_read = 1'b1; hz.e_rd = 3'd3;
    hz.d_rs1 = 3'd3; hz.d_use_rs1 = 1'b1;
    expect_cycle("loaduse_e", C_BUBBLE, 2'b00, 2'b00);
    hz.e_reg_write = 1'b0; hz.e_mem_read = 1'b0; hz.e_rd = 3'd0;
    hz.w_reg_write = 1'b1; hz.w_rd = 3'd3;
    expect_cycle("loaduse_w", FWD ? C_IDLE : C_BUBBLE, FWD ? 2'b10 : 2'b00, 2'b00);
    clear_inputs();
    expect_cycle("loaduse_done", C_IDLE, 2'b00, 2'b00);

    // ALU RAW on rs2
    hz.e_reg_write = 1'b1; hz.e_rd = 3'd5; hz.d_rs2 = 3'd5; hz.d_use_rs2 = 1'b1;
    expect_cycle("alu_raw_e", FWD ? C_IDLE : C_BUBBLE, 2'b00, FWD ? 2'b01 : 2'b00);
    hz.e_reg_write = 1'b0; hz.e_rd = 3'd0; hz.w_reg_write = 1'b1; hz.w_rd = 3'd5;
    expect_cycle("alu_raw_w", FWD ? C_IDLE : C_BUBBLE, 2'b00, FWD ? 2'b10 : 2'b00);
    hz.e_reg_write = 1'b1; hz.e_rd = 3'd5;
    expect_cycle("alu_raw_e_over_w", FWD ? C_IDLE : C_BUBBLE, 2'b00, FWD ? 2'b01 : 2'b00);
    hz.d_use_rs2 = 1'b0;
    expect_cycle("unused_src", C_IDLE, 2'b00, 2'b00);
    clear_inputs();

    // Multi-cycle op held for MC cycles
    hz.e_multicycle = 1'b1;
    expect_cycle("mc_c1", C_MC, 2'b00, 2'b00);
    hz.halt_req = 1'b1;
    expect_cycle("mc_c2", C_MC, 2'b00, 2'b00);
    hz.halt_req = 1'b0;
    expect_cycle("mc_c3", C_MC, 2'b00, 2'b00);
    expect_cycle("mc_final", C_IDLE, 2'b00, 2'b00);
    hz.e_multicycle = 1'b0;
    expect_cycle("mc_back_run", C_IDLE, 2'b00, 2'b00);

    // Branch together with a load-use hazard
    hz.e_branch_taken = 1'b1; hz.e_reg_write = 1'b1; hz.e_mem_read = 1'b1;
    hz.e_rd = 3'd3; hz.d_rs1 = 3'd3; hz.d_use_rs1 = 1'b1;
    expect_cycle("branch_loaduse", C_BRANCH, 2'b00, 2'b00);
    clear_inputs();
    expect_cycle("branch_after", C_IDLE, 2'b00, 2'b00);

    // Branch wins over a multi-cycle op
    hz.e_branch_taken = 1'b1; hz.e_multicycle = 1'b1;
    expect_cycle("branch_mc", C_BRANCH, 2'b00, 2'b00);
    clear_inputs();
    expect_cycle("branch_mc_no_multi", C_IDLE, 2'b00, 2'b00);

    // Debug halt: two drain cycles, then acked halt
    hz.halt_req = 1'b1;
    expect_cycle("halt_req_run", C_IDLE, 2'b00, 2'b00);
    expect_cycle("drain_0", C_BUBBLE, 2'b00, 2'b00);
    expect_cycle("drain_1", C_BUBBLE, 2'b00, 2'b00);
    expect_cycle("halted_0", C_HALT, 2'b00, 2'b00);
    expect_cycle("halted_1", C_HALT, 2'b00, 2'b00);
    hz.halt_req = 1'b0;
    expect_cycle("halted_release", C_HALT, 2'b00, 2'b00);
    expect_cycle("resume_run", C_IDLE, 2'b00, 2'b00);

    // Halt request withdrawn mid-drain
    hz.halt_req = 1'b1;
    expect_cycle("abort_req", C_IDLE, 2'b00, 2'b00);
    expect_cycle("abort_drain_0", C_BUBBLE, 2'b00, 2'b00);
    hz.halt_req = 1'b0;
    expect_cycle("abort_drain_1", C_BUBBLE, 2'b00, 2'b00);
    expect_cycle("abort_run", C_IDLE, 2'b00, 2'b00);
    expect_cycle("abort_no_ack", C_IDLE, 2'b00, 2'b00);

    // Branch during drain still counts as a drain cycle
    hz.halt_req = 1'b1;
    expect_cycle("bdrain_req", C_IDLE, 2'b00, 2'b00);
    hz.e_branch_taken = 1'b1;
    expect_cycle("bdrain_0_branch", C_BRANCH, 2'b00, 2'b00);
    hz.e_branch_taken = 1'b0;
    expect_cycle("bdrain_1", C_BUBBLE, 2'b00, 2'b00);
    expect_cycle("bdrain_halted", C_HALT, 2'b00, 2'b00);
    hz.halt_req = 1'b0;
    expect_cycle("bdrain_release", C_HALT, 2'b00, 2'b00);
    expect_cycle("bdrain_run", C_IDLE, 2'b00, 2'b00);

    // Reset in the middle of a multi-cycle op
    hz.e_multicycle = 1'b1;
    expect_cycle("rst_mc_c1", C_MC, 2'b00, 2'b00);
    expect_cycle("rst_mc_c2", C_MC, 2'b00, 2'b00);
    reset = 1'b1;
    #1;
    check("rst_mid_multi", obs, {C_ZERO, 4'b0000});
    @(posedge clk); #1;
    reset = 1'b0;
    hz.e_multicycle = 1'b0;
    expect_cycle("rst_after_run", C_IDLE, 2'b00, 2'b00);
    hz.e_multicycle = 1'b1;
    expect_cycle("rst_fresh_c1", C_MC, 2'b00, 2'b00);
    expect_cycle("rst_fresh_c2", C_MC, 2'b00, 2'b00);
    expect_cycle("rst_fresh_c3", C_MC, 2'b00, 2'b00);
    expect_cycle("rst_fresh_final", C_IDLE, 2'b00, 2'b00);
    clear_inputs();
    expect_cycle("end_idle", C_IDLE, 2'b00, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

- Central hazard controller for the F → FD → D → DE → E → EW → W pipeline.
- Drives the stall and flush inputs of the F/D and D/E stage registers, the PC write enable and the branch redirect select.
- Sequences multi-cycle execute operations and a debug halt/drain handshake.
- Resolves read-after-write (RAW) hazards by stalling, or by forwarding selects when forwarding is compiled in.

## Interface
Parameters:
- MC_CYCLES, 4: total cycles a multi-cycle op occupies E. Legal range 2..16.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high. FSM → RUN, cnt → 0. All outputs forced to 0 while reset is high.
- d_rs1, d_rs2  in  3 each  decode-stage source register addresses.
- d_use_rs1, d_use_rs2  in  1 each  decode instruction actually reads rs1 / rs2.
- e_rd  in  3  destination register of the instruction in E.
- e_reg_write  in  1  E instruction writes the register file.
- e_mem_read  in  1  E instruction is a load.
- e_multicycle  in  1  E instruction is a multi-cycle op.
- e_branch_taken  in  1  E resolved a taken branch or jump.
- w_rd  in  3  destination register of the instruction in W.
- w_reg_write  in  1  W instruction writes the register file.
- halt_req  in  1  debug halt request; level-sensitive.
- stall_F, stall_D  out  1 each  hold the F/D and D/E registers.
- flush_F, flush_D  out  1 each  NOP the F/D and D/E registers.
- pc_write_en  out  1  PC register update enable.
- pc_sel_branch  out  1  PC loads the branch target.
- wb_suppress  out  1  gates reg_write into E/W (non-final multi-cycle cycles).
- halt_ack  out  1  registered; pipeline drained and halted.
- fwd_a, fwd_b  out  2 each  operand source for rs1 / rs2: 00 = register file, 01 = E result, 10 = W result.

## Operation
- FSM states: RUN, MULTI, DRAIN, HALTED. Counter cnt is 4 bits.
- Matches:
  - mE = e_reg_write & e_rd matches a used decode source.
  - mW = w_reg_write & w_rd matches a used decode source.
  - loaduse = mE & e_mem_read.
- Branch overrides every state except MULTI.
  - Drives flush_F=1, flush_D=1, pc_sel_branch=1, pc_write_en=1.
  - Drives stall_F=0, stall_D=0, wb_suppress=0.
  - If e_branch_taken and e_multicycle are both high, the branch wins and the FSM does not enter MULTI.
- RUN, no branch:
  - Priority is e_multicycle, then RAW stall, then halt_req.
  - e_multicycle: stall_F=stall_D=wb_suppress=1, pc_write_en=0. Next state MULTI with cnt=1.
  - RAW stall: stall_F=1, flush_D=1 (bubble into D/E), pc_write_en=0.
  - halt_req: next state DRAIN with cnt=0. Outputs this cycle are the normal RUN outputs.
- MULTI:
  - While cnt < MC_CYCLES-1: stall_F=stall_D=wb_suppress=1, pc_write_en=0, cnt increments.
  - When cnt = MC_CYCLES-1 (final cycle): all stalls are released, the result enters E/W, and the next state is RUN.
  - halt_req is ignored until RUN.
- DRAIN:
  - Outputs stall_F=1, flush_D=1, pc_write_en=0; cnt increments.
  - After 2 DRAIN cycles (cnt=1), next state is HALTED.
  - If halt_req drops during DRAIN, return to RUN next cycle without acking.
  - A branch in a DRAIN cycle applies the branch overrides and still counts as a drain cycle.
- HALTED:
  - Outputs stall_F=1, flush_D=1, pc_write_en=0, halt_ack=1.
  - When halt_req=0, next state is RUN.
- pc_write_en = 1 in every case not listed above.

## Timing
- All stall/flush/PC outputs are combinational from the FSM state and the current-cycle inputs. Zero-cycle latency to the stage registers.
- Load-use costs exactly 1 bubble with forwarding, 2 bubbles without.
- A multi-cycle op holds F, D and E for MC_CYCLES-1 cycles; its E/W write occurs in the MC_CYCLES-th cycle.
- halt_ack rises on the 3rd cycle after halt_req is sampled in RUN. It falls the cycle after halt_req is sampled low in HALTED.
- Reset mid-MULTI or mid-DRAIN: the op is abandoned, and RUN starts on the first edge after reset deasserts.

## Configuration
- Macro: HAZARD_FWD_EN.
- Defined:
  - RAW stall = loaduse only.
  - fwd_a / fwd_b = 01 if mE (and not a load), else 10 if mW, else 00, evaluated per operand.
  - E takes priority over W.
- Undefined:
  - RAW stall = mE | mW.
  - fwd_a = fwd_b = 00 constantly.

## Test plan
- Load-use, HAZARD_FWD_EN defined: e_mem_read=1, e_rd=3, d_rs1=3, d_use_rs1=1 → 1 cycle of stall_F=1, flush_D=1, pc_write_en=0. Next cycle w_rd=3 gives fwd_a=10 and no stall.
- ALU RAW: e_reg_write=1, e_rd=5, d_rs2=5, d_use_rs2=1.
  - With HAZARD_FWD_EN: fwd_b=01, no stall.
  - Without: 2 consecutive bubble cycles.
- Multi-cycle, MC_CYCLES=4: e_multicycle=1 held → stall_F=stall_D=wb_suppress=1 for 3 cycles, all 0 in the 4th, FSM back in RUN.
- Branch plus load-use in the same cycle: e_branch_taken=1 → flush_F=flush_D=1, pc_sel_branch=1, pc_write_en=1, stall_F=0.
- Halt: halt_req=1 in RUN → 2 DRAIN cycles with flush_D=1, halt_ack=1 from the 3rd cycle. halt_req=0 → halt_ack=0 and pc_write_en=1 the next cycle.
- Reset asserted in MULTI with cnt=2 → outputs 0 immediately. After release, e_multicycle=0 gives normal RUN operation.
